fruit_launcher: RTL and testbench

FRUIT_LAUNCHER -- requirements
Module: fruit_launcher

---
 rtl/fruit_launcher_pkg.sv | 10 +
 rtl/fruit_launcher_if.sv | 16 +
 rtl/fruit_launcher_period_ramp.sv | 15 +
 rtl/fruit_launcher.sv | 84 ++++++++
 tb/tb_fruit_launcher.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fruit_launcher_pkg.sv
// fruit_launcher_pkg: flight state encoding, screen and period defaults, and a small max helper
package fruit_launcher_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, RISE, FALL, FINISH} state_t;
  localparam int DEF_SCREEN_W = 640;
  localparam int DEF_SCREEN_H = 480;
  localparam int DEF_MIN_PERIOD = 1000;
  function automatic logic [31:0] max32(input logic [31:0] a, input logic [31:0] b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/fruit_launcher_if.sv
// fruit_launcher_if: launch request, flight parameters, mover feedback and mover controls
interface fruit_launcher_if;
  logic launch, abort, startDir;
  logic [9:0] startX, posx, initPosX;
  logic [8:0] floorY, posy, initPosY;
  logic [31:0] periodX, riseT0, gravity, apexT, Tx, Ty;
  logic dx, dy, objRst, active, done;
  modport master (
    output launch, abort, startX, startDir, periodX, riseT0, gravity, apexT, floorY, posx, posy,
    input Tx, Ty, dx, dy, initPosX, initPosY, objRst, active, done
  );
  modport slave (
    input launch, abort, startX, startDir, periodX, riseT0, gravity, apexT, floorY, posx, posy,
    output Tx, Ty, dx, dy, initPosX, initPosY, objRst, active, done
  );
endinterface

// File: rtl/fruit_launcher_period_ramp.sv
// period_ramp: next vertical period, saturating when growing and clamped at a floor when shrinking
module period_ramp (
  input  logic [31:0] period,
  input  logic [31:0] step,
  input  logic        dir,
  input  logic [31:0] floor,
  output logic [31:0] next
);
  logic [32:0] w_sum;
  logic [31:0] w_diff;
  assign w_sum = {1'b0, period} + {1'b0, step};
  assign w_diff = period - step;
  assign next = dir ? (w_sum[32] ? '1 : w_sum[31:0])
                    : ((period < step || w_diff < floor) ? floor : w_diff);
endmodule

// File: rtl/fruit_launcher.sv
// fruit_launcher: steers a pixel mover through a rise/apex/fall flight by ramping its vertical period
module fruit_launcher import fruit_launcher_pkg::*; #(
  parameter int MIN_PERIOD = DEF_MIN_PERIOD,
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int SCREEN_H = DEF_SCREEN_H
) (
  input logic clk,
  input logic rst,
  fruit_launcher_if.slave bus
);
  localparam logic [31:0] MINP = 32'(MIN_PERIOD);
  localparam logic [9:0] X_MAX = 10'(SCREEN_W - 1);
  localparam logic [8:0] Y_MAX = 9'(SCREEN_H - 1);
  state_t r_state, w_next;
  logic [31:0] r_tx, r_ty, r_grav, r_apex, w_ty_next;
  logic [9:0] r_init_x;
  logic [8:0] r_init_y, r_floor, r_posy_q;
  logic r_dx, r_dy;
  logic w_fly, w_go, w_ystep, w_offscreen, w_apex;
  assign w_fly = r_state == RISE || r_state == FALL;
  assign w_go = r_state == IDLE && bus.launch && !bus.abort;
  assign w_ystep = bus.posy != r_posy_q;
  assign w_offscreen = (bus.posx == '0 && !r_dx) || (bus.posx == X_MAX && r_dx);
  assign w_apex = (w_ystep && w_ty_next >= r_apex) || bus.posy == '0;
  period_ramp u_ramp (
    .period(r_ty),
    .step  (r_grav),
    .dir   (r_state == RISE),
    .floor (MINP),
    .next  (w_ty_next)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_go ? LOAD : IDLE;
      LOAD:    w_next = RISE;
      RISE:    w_next = w_offscreen ? FINISH : w_apex ? FALL : RISE;
      FALL:    w_next = (w_offscreen || bus.posy >= r_floor) ? FINISH : FALL;
      default: w_next = IDLE;
    endcase
    if (bus.abort) w_next = IDLE;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_tx <= MINP;
      r_ty <= MINP;
      r_dx <= 1'b0;
      r_dy <= 1'b0;
      r_init_x <= '0;
      r_init_y <= '0;
      r_floor <= '0;
      r_grav <= '0;
      r_apex <= '0;
      r_posy_q <= '0;
    end else begin
      // the mover is reloaded to initPosY on leaving LOAD, so that reload must not count as a y-step
      r_posy_q <= r_state == LOAD ? r_init_y : bus.posy;
      if (w_go) begin
        r_tx <= max32(bus.periodX, MINP);
        r_ty <= max32(bus.riseT0, MINP);
        r_dx <= bus.startDir;
        r_dy <= 1'b0;
        r_init_x <= bus.startX;
        r_init_y <= bus.floorY;
        r_floor <= bus.floorY > Y_MAX ? Y_MAX : bus.floorY;
        r_grav <= bus.gravity;
        r_apex <= bus.apexT;
      end
      if (w_fly && w_ystep) r_ty <= w_ty_next;
      if (r_state == RISE && w_apex) r_dy <= 1'b1;
    end
  assign bus.Tx = r_tx;
  assign bus.Ty = r_ty;
  assign bus.dx = r_dx;
  assign bus.dy = r_dy;
  assign bus.initPosX = r_init_x;
  assign bus.initPosY = r_init_y;
  assign bus.objRst = !w_fly;
  assign bus.active = w_fly;
  assign bus.done = r_state == FINISH;
endmodule

// File: tb/tb_fruit_launcher.sv
// tb_fruit_launcher: random and directed flights scored against a flight-level reference model
module tb_fruit_launcher;
  localparam int MINP = 10;
  typedef struct {
    logic [31:0] tx;
    logic [31:0] peak;
    logic [31:0] fin;
  } exp_t;
  logic clk = 0;
  logic rst = 0;
  always #5 clk = ~clk;
  fruit_launcher_if bus();
  fruit_launcher #(.MIN_PERIOD(MINP)) dut (.clk(clk), .rst(rst), .bus(bus));

  // position mover: one pixel per Tx/Ty cycles, or hand-driven when manual is set
  logic manual = 0;
  logic [9:0] man_x = 0, mv_x = 0;
  logic [8:0] man_y = 0, mv_y = 0;
  logic [31:0] cx = 0, cy = 0;
  assign bus.posx = manual ? man_x : mv_x;
  assign bus.posy = manual ? man_y : mv_y;
  always @(posedge clk)
    if (bus.objRst) begin
      mv_x <= bus.initPosX;
      mv_y <= bus.initPosY;
      cx <= 0;
      cy <= 0;
    end else begin
      cx <= (cx + 32'd1 >= bus.Tx) ? 32'd0 : cx + 32'd1;
      cy <= (cy + 32'd1 >= bus.Ty) ? 32'd0 : cy + 32'd1;
      if (cx + 32'd1 >= bus.Tx) mv_x <= bus.dx ? mv_x + 10'd1 : mv_x - 10'd1;
      if (cy + 32'd1 >= bus.Ty) mv_y <= bus.dy ? mv_y + 9'd1 : mv_y - 9'd1;
    end

  int total = 0, bad = 0, n_done = 0;
  exp_t sb[$];
  exp_t e;
  logic [31:0] mx = 0, seen_tx = 0;
  logic prev_done = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, want, $time);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] tx, input logic [31:0] peak, input logic [31:0] fin);
    exp_t r;
    r.tx = tx;
    r.peak = peak;
    r.fin = fin;
    return r;
  endfunction

  // climb one row per step until the apex period or the top row, then fall the same number of rows
  function automatic exp_t model(input logic [31:0] px, input logic [31:0] t0, input logic [31:0] g,
                                 input logic [31:0] ap, input int fy);
    longint ty, lo;
    int y, k;
    exp_t r;
    lo = MINP;
    ty = t0 < lo ? lo : t0;
    y = fy;
    k = 0;
    do begin
      ty = ty + g;
      if (ty > 64'hFFFF_FFFF) ty = 64'hFFFF_FFFF;
      y--;
      k++;
    end while (ty < ap && y != 0);
    r.peak = 32'(ty);
    repeat (k) begin
      ty = ty - g;
      if (ty < lo) ty = lo;
    end
    r.fin = 32'(ty);
    r.tx = 32'(px < lo ? lo : px);
    return r;
  endfunction

  always @(negedge clk) begin
    if (prev_done) chk("done_width", {31'b0, bus.done}, 0);
    prev_done = bus.done;
    if (bus.active) begin
      if (bus.Ty > mx) mx = bus.Ty;
      seen_tx = bus.Tx;
    end
    if (bus.done) begin
      n_done++;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done at %0t", $time);
      end else begin
        e = sb.pop_front();
        chk("tx", seen_tx, e.tx);
        chk("peak_ty", mx, e.peak);
        chk("final_ty", bus.Ty, e.fin);
        chk("done_objrst", {31'b0, bus.objRst}, 1);
      end
    end
    if (!bus.active) mx = 0;
  end

  task automatic launch_it(input logic [9:0] sx, input logic sd, input logic [31:0] px, input logic [31:0] t0,
                           input logic [31:0] g, input logic [31:0] ap, input logic [8:0] fy);
    @(negedge clk);
    bus.startX = sx;
    bus.startDir = sd;
    bus.periodX = px;
    bus.riseT0 = t0;
    bus.gravity = g;
    bus.apexT = ap;
    bus.floorY = fy;
    bus.launch = 1;
    @(negedge clk);
    bus.launch = 0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int n0;
    n0 = n_done;
    for (int i = 0; i < budget && n_done == n0; i++) @(negedge clk);
    if (n_done == n0) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: no done within %0d cycles", name, budget);
    end
    @(negedge clk);
  endtask

  task automatic mstep(input logic [8:0] y);
    man_y = y;
    @(negedge clk);
  endtask

  task automatic abort_it();
    bus.abort = 1;
    @(negedge clk);
    bus.abort = 0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_tx"}, bus.Tx, MINP);
    chk({tag, "_ty"}, bus.Ty, MINP);
    chk({tag, "_dxdy"}, {30'b0, bus.dx, bus.dy}, 0);
    chk({tag, "_init"}, {13'b0, bus.initPosX, bus.initPosY}, 0);
    chk({tag, "_flags"}, {29'b0, bus.objRst, bus.active, bus.done}, 32'b100);
  endtask

  logic [31:0] t0, g, ap, px, te;
  logic [8:0] fy;
  logic [9:0] sx;

  initial begin
    bus.launch = 0;
    bus.abort = 0;
    bus.startX = 0;
    bus.startDir = 0;
    bus.periodX = 0;
    bus.riseT0 = 0;
    bus.gravity = 0;
    bus.apexT = 0;
    bus.floorY = 0;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst = 1;
    sb.push_back(model(1000, 10, 10, 200, 400));
    launch_it(320, 1, 1000, 10, 10, 200, 400);
    wait_done(20000, "normal");
    for (int n = 0; n < 8; n++) begin
      t0 = $urandom_range(40, 0);
      g = $urandom_range(10, 1);
      te = t0 < MINP ? MINP : t0;
      ap = te + $urandom_range(12, 1) * g - $urandom_range(g - 1, 0);
      px = $urandom_range(600, 300);
      fy = 9'($urandom_range(479, 100));
      sx = 10'($urandom_range(500, 100));
      sb.push_back(model(px, t0, g, ap, int'(fy)));
      launch_it(sx, 1'($urandom_range(1, 0)), px, t0, g, ap, fy);
      wait_done(20000, "random");
    end
    // off-screen: reaches column 639 long before the first vertical step
    sb.push_back(mk(1000, 5000, 5000));
    launch_it(638, 1, 1000, 5000, 10, 100000, 400);
    wait_done(3000, "offscreen");
    manual = 1;
    man_x = 300;
    // clamp: falling period stops at MIN_PERIOD
    man_y = 50;
    sb.push_back(mk(MINP, 25, MINP));
    launch_it(300, 0, 3, 15, 10, 25, 50);
    @(negedge clk);
    chk("clamp_active", {31'b0, bus.active}, 1);
    mstep(49);
    chk("apex_ty", bus.Ty, 25);
    chk("apex_dy", {31'b0, bus.dy}, 1);
    mstep(48);
    chk("fall_ty", bus.Ty, 15);
    mstep(47);
    chk("clamp_ty", bus.Ty, MINP);
    mstep(50);
    @(negedge clk);
    // top row forces the fall even below the apex period
    man_y = 3;
    launch_it(300, 0, 50, 10, 1, 1000, 3);
    @(negedge clk);
    mstep(2);
    mstep(1);
    chk("rise_ty", bus.Ty, 12);
    chk("rise_dy", {31'b0, bus.dy}, 0);
    mstep(0);
    chk("top_ty", bus.Ty, 13);
    chk("top_dy", {31'b0, bus.dy}, 1);
    abort_it();
    chk("abort_flags", {30'b0, bus.objRst, bus.active}, 32'b10);
    // saturation at the top of the period range
    man_y = 50;
    launch_it(300, 0, 50, 32'hFFFF_FF00, 32'h200, 32'hFFFF_FFFF, 50);
    @(negedge clk);
    chk("sat_start_ty", bus.Ty, 32'hFFFF_FF00);
    mstep(49);
    chk("sat_ty", bus.Ty, 32'hFFFF_FFFF);
    chk("sat_dy", {31'b0, bus.dy}, 1);
    abort_it();
    // abort and launch together while rising
    launch_it(300, 0, 50, 100, 10, 1000, 50);
    @(negedge clk);
    bus.launch = 1;
    bus.abort = 1;
    @(negedge clk);
    bus.launch = 0;
    bus.abort = 0;
    chk("collide_flags", {30'b0, bus.objRst, bus.active}, 32'b10);
    repeat (3) @(negedge clk);
    chk("collide_norelaunch", {31'b0, bus.active}, 0);
    // asynchronous reset while falling
    launch_it(300, 1, 50, 20, 10, 30, 50);
    @(negedge clk);
    mstep(49);
    chk("pre_rst_dy", {31'b0, bus.dy}, 1);
    #1 rst = 0;
    #1 chk_reset_vals("async");
    @(negedge clk);
    rst = 1;
    repeat (2) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
